sprite_drawer: RTL and testbench

- Responder end of the draw-request handshake raised by the movement controller (drawBG/drawChar with doneBG/doneChar).
- On a request it latches the sprite's top-left anchor and scans a SPRITE_W x SPRITE_H window.
- Each pixel's colour is fetched from either the background ROM or the character ROM, then written to the VGA adapter via x/y/colour/plot.
- Sits between the movement FSM, the two synchronous ROMs and the VGA adapter.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/pixel_scan_counter.sv | 60 ++++++
 rtl/sprite_drawer.sv | 166 ++++++++++++++++
 tb/tb_sprite_drawer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite drawer: screen geometry, FSM state codes, draw kinds and
// the background ROM address helper.
package sprite_pkg;

    localparam int unsigned SCREEN_W  = 320;
    localparam int unsigned SCREEN_H  = 240;
    localparam int unsigned BG_ADDR_W = 17;

    // FSM state codes
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLatch   = 3'd1;
    localparam logic [2:0] StScan    = 3'd2;
    localparam logic [2:0] StFlush   = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;
    localparam logic [2:0] StRelease = 3'd5;

    // Kind of draw request being serviced
    localparam logic KindBg   = 1'b0;
    localparam logic KindChar = 1'b1;

    // Linear background ROM address for an on-screen pixel (y*320 + x).
    function automatic logic [BG_ADDR_W-1:0] bg_addr(input logic [9:0] x, input logic [8:0] y);
        return BG_ADDR_W'(y) * BG_ADDR_W'(SCREEN_W) + BG_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster counter over a SPRITE_W x SPRITE_H window.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         return to (0,0); has priority over enable_i
//   enable_i        advance one pixel; col wraps at SPRITE_W-1 and bumps row
//   col_o, row_o    current pixel position inside the window
//   last_o          high while the counter sits on the bottom-right pixel
module pixel_scan_counter #(
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned SPRITE_H = 8,
    localparam int unsigned COL_W = $clog2(SPRITE_W),
    localparam int unsigned ROW_W = $clog2(SPRITE_H)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_last, row_last;

    assign col_last = (col_q == COL_W'(SPRITE_W - 1));
    assign row_last = (row_q == ROW_W'(SPRITE_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (enable_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_last && row_last;

endmodule

// File: rtl/sprite_drawer.sv
// Sprite drawer: answers drawBG/drawChar requests by scanning a SPRITE_W x SPRITE_H window
// anchored at (xCoordinate, yCoordinate), fetching each pixel from the background or
// character ROM and writing it to the VGA adapter.
// Ports:
//   clock, resetn            clock, asynchronous active-low reset
//   drawBG, drawChar         level requests (BG wins when both are high)
//   xCoordinate, yCoordinate sprite top-left anchor
//   bgAddr/bgData            background ROM (data one cycle after address)
//   charAddr/charData        character ROM (data one cycle after address)
//   vgaX, vgaY, colour, plot VGA adapter write port
//   doneBG, doneChar         one-cycle completion pulses
// Build option: define CHAR_TRANSPARENCY_EN to suppress plotting of character pixels whose
// colour equals TRANSPARENT.
module sprite_drawer
    import sprite_pkg::*;
#(
    parameter int unsigned          SPRITE_W    = 8,
    parameter int unsigned          SPRITE_H    = 8,
    parameter int unsigned          COLOUR_W    = 3,
    parameter logic [COLOUR_W-1:0]  TRANSPARENT = '0,
    localparam int unsigned COL_W       = $clog2(SPRITE_W),
    localparam int unsigned ROW_W       = $clog2(SPRITE_H),
    localparam int unsigned CHAR_ADDR_W = COL_W + ROW_W
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   drawBG,
    input  logic                   drawChar,
    input  logic [8:0]             xCoordinate,
    input  logic [7:0]             yCoordinate,
    output logic [BG_ADDR_W-1:0]   bgAddr,
    input  logic [COLOUR_W-1:0]    bgData,
    output logic [CHAR_ADDR_W-1:0] charAddr,
    input  logic [COLOUR_W-1:0]    charData,
    output logic [8:0]             vgaX,
    output logic [7:0]             vgaY,
    output logic [COLOUR_W-1:0]    colour,
    output logic                   plot,
    output logic                   doneBG,
    output logic                   doneChar
);

`ifdef CHAR_TRANSPARENCY_EN
    localparam bit TranspEn = 1'b1;
`else
    localparam bit TranspEn = 1'b0;
`endif

    logic [2:0] state_q, state_d;
    logic       kind_q, kind_d;
    logic [8:0] anchor_x_q, anchor_x_d;
    logic [7:0] anchor_y_q, anchor_y_d;
    logic [8:0] vga_x_q, vga_x_d;
    logic [7:0] vga_y_q, vga_y_d;
    logic       plot_q, plot_d;
    logic       done_bg_q, done_bg_d;
    logic       done_char_q, done_char_d;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_pixel;
    logic             scanning;
    logic [9:0]       x_sum;
    logic [8:0]       y_sum;
    logic             in_screen;
    logic             req_held;
    logic             transparent_hit;

    assign scanning = (state_q == StScan);

    pixel_scan_counter #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_scan (
        .clk_i    (clock),
        .rst_ni   (resetn),
        .clear_i  (state_q == StLatch),
        .enable_i (scanning),
        .col_o    (col),
        .row_o    (row),
        .last_o   (last_pixel)
    );

    // Widened sums so pixels hanging off the right/bottom edge are detected, not wrapped.
    assign x_sum     = {1'b0, anchor_x_q} + 10'(col);
    assign y_sum     = {1'b0, anchor_y_q} + 9'(row);
    assign in_screen = (x_sum < 10'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));

    // Off-screen pixels read address 0 so the ROM is never addressed past its end.
    assign bgAddr   = (scanning && in_screen) ? bg_addr(x_sum, y_sum) : '0;
    assign charAddr = scanning ? {row, col} : '0;

    assign req_held = (kind_q == KindChar) ? drawChar : drawBG;

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        case (state_q)
            StIdle: begin
                if (drawBG) begin
                    state_d = StLatch;
                    kind_d  = KindBg;
                end else if (drawChar) begin
                    state_d = StLatch;
                    kind_d  = KindChar;
                end
            end
            StLatch: begin
                anchor_x_d = xCoordinate;
                anchor_y_d = yCoordinate;
                state_d    = StScan;
            end
            StScan:    if (last_pixel) state_d = StFlush;
            StFlush:   state_d = StDone;
            StDone:    state_d = StRelease;
            // Hold here until the serviced request drops so a held level cannot retrigger.
            StRelease: if (!req_held) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output stage: aligned with ROM data, which arrives one cycle after the address.
    always_comb begin
        vga_x_d     = scanning ? x_sum[8:0] : vga_x_q;
        vga_y_d     = scanning ? y_sum[7:0] : vga_y_q;
        plot_d      = scanning && in_screen;
        done_bg_d   = (state_q == StFlush) && (kind_q == KindBg);
        done_char_d = (state_q == StFlush) && (kind_q == KindChar);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            kind_q      <= KindBg;
            anchor_x_q  <= '0;
            anchor_y_q  <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            plot_q      <= 1'b0;
            done_bg_q   <= 1'b0;
            done_char_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            anchor_x_q  <= anchor_x_d;
            anchor_y_q  <= anchor_y_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            plot_q      <= plot_d;
            done_bg_q   <= done_bg_d;
            done_char_q <= done_char_d;
        end
    end

    assign transparent_hit = TranspEn && (kind_q == KindChar) && (charData == TRANSPARENT);

    assign vgaX     = vga_x_q;
    assign vgaY     = vga_y_q;
    assign plot     = plot_q && !transparent_hit;
    assign colour   = plot_q ? ((kind_q == KindChar) ? charData : bgData) : '0;
    assign doneBG   = done_bg_q;
    assign doneChar = done_char_q;

endmodule

// File: tb/tb_sprite_drawer.sv
module tb_sprite_drawer;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;

`ifdef CHAR_TRANSPARENCY_EN
    localparam bit TranspEn = 1'b1;
`else
    localparam bit TranspEn = 1'b0;
`endif

    logic        clock;
    logic        resetn;
    logic        drawBG;
    logic        drawChar;
    logic [8:0]  xCoordinate;
    logic [7:0]  yCoordinate;
    logic [16:0] bgAddr;
    logic [2:0]  bgData;
    logic [5:0]  charAddr;
    logic [2:0]  charData;
    logic [8:0]  vgaX;
    logic [7:0]  vgaY;
    logic [2:0]  colour;
    logic        plot;
    logic        doneBG;
    logic        doneChar;

    logic [2:0]  char_mem [NPIX];
    int unsigned bg_seed;
    int          n_vec;
    int          n_err;
    int          plots;

    sprite_drawer u_dut (
        .clock       (clock),
        .resetn      (resetn),
        .drawBG      (drawBG),
        .drawChar    (drawChar),
        .xCoordinate (xCoordinate),
        .yCoordinate (yCoordinate),
        .bgAddr      (bgAddr),
        .bgData      (bgData),
        .charAddr    (charAddr),
        .charData    (charData),
        .vgaX        (vgaX),
        .vgaY        (vgaY),
        .colour      (colour),
        .plot        (plot),
        .doneBG      (doneBG),
        .doneChar    (doneChar)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] bg_fn(input int unsigned a);
        return 3'((a * 5 + (a >> 4) + bg_seed) % 8);
    endfunction

    // Synchronous ROM models
    always @(posedge clock) begin
        bgData   <= bg_fn(int'(bgAddr));
        charData <= char_mem[charAddr];
    end

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at the negedge of the IDLE cycle in which the request is first seen high.
    // Walks the 67 cycles up to and including the done pulse.
    task automatic draw_and_check(input bit is_char, input int ax, input int ay,
                                  output int n_plots);
        bit inscr [NPIX];
        bit vis   [NPIX];
        int ex    [NPIX];
        int ey    [NPIX];
        int n;
        bit exp_plot;
        int exp_col;
        n_plots = 0;
        for (int p = 0; p < NPIX; p++) begin
            ex[p]    = ax + p % W;
            ey[p]    = ay + p / W;
            inscr[p] = (ex[p] < 320) && (ey[p] < 240);
            vis[p]   = inscr[p] && !(TranspEn && is_char && char_mem[p] == 3'd0);
        end
        for (int j = 1; j <= 67; j++) begin
            @(negedge clock);
            if (j >= 2 && j <= 65) begin
                n = j - 2;
                check_val("charAddr", charAddr, n);
                if (inscr[n]) check_val("bgAddr", bgAddr, ey[n] * 320 + ex[n]);
                else          check_val("bgAddr_max", bgAddr <= 17'd76799, 1);
            end
            exp_plot = (j >= 3 && j <= 66) ? vis[j - 3] : 1'b0;
            check_val("plot", plot, exp_plot);
            if (plot === 1'b1) n_plots++;
            if (exp_plot && plot === 1'b1) begin
                n = j - 3;
                exp_col = is_char ? int'(char_mem[n]) : int'(bg_fn(ey[n] * 320 + ex[n]));
                check_val("vgaX", vgaX, ex[n]);
                check_val("vgaY", vgaY, ey[n]);
                check_val("colour", colour, exp_col);
            end
            check_val("doneBG", doneBG, (j == 67) && !is_char);
            check_val("doneChar", doneChar, (j == 67) && is_char);
        end
    endtask

    // Hold the request for extra cycles (nothing may happen), then drop it and return to IDLE.
    task automatic release_req(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_val("hold_plot", plot, 0);
            check_val("hold_done", doneBG | doneChar, 0);
        end
        drawBG   = 1'b0;
        drawChar = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        bg_seed     = $urandom;
        drawBG      = 1'b0;
        drawChar    = 1'b0;
        xCoordinate = '0;
        yCoordinate = '0;
        for (int p = 0; p < NPIX; p++) char_mem[p] = 3'd0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_plot", plot, 0);
        check_val("rst_doneBG", doneBG, 0);
        check_val("rst_doneChar", doneChar, 0);
        check_val("rst_vgaX", vgaX, 0);
        check_val("rst_vgaY", vgaY, 0);
        check_val("rst_colour", colour, 0);
        check_val("rst_bgAddr", bgAddr, 0);
        check_val("rst_charAddr", charAddr, 0);
        resetn = 1'b1;
        @(negedge clock);

        // Background redraw near the bottom of the screen
        xCoordinate = 9'd95; yCoordinate = 8'd221; drawBG = 1'b1;
        draw_and_check(1'b0, 95, 221, plots);
        check_val("t1_plots", plots, 64);
        release_req(0);

        // Character draw with charData = address, request held afterwards
        for (int p = 0; p < NPIX; p++) char_mem[p] = 3'(p % 8);
        xCoordinate = 9'd126; yCoordinate = 8'd68; drawChar = 1'b1;
        draw_and_check(1'b1, 126, 68, plots);
        check_val("t2_plots", plots, TranspEn ? 56 : 64);
        release_req(10);

        // Simultaneous requests: BG first, CHAR after BG drops
        xCoordinate = 9'd10; yCoordinate = 8'd20; drawBG = 1'b1; drawChar = 1'b1;
        draw_and_check(1'b0, 10, 20, plots);
        check_val("t3_bg_plots", plots, 64);
        drawBG = 1'b0;
        repeat (2) @(negedge clock);
        xCoordinate = 9'd200; yCoordinate = 8'd100;
        draw_and_check(1'b1, 200, 100, plots);
        release_req(0);

        // Bottom-right corner clipping
        xCoordinate = 9'd316; yCoordinate = 8'd236; drawBG = 1'b1;
        draw_and_check(1'b0, 316, 236, plots);
        check_val("t4_plots", plots, 16);
        release_req(0);

        // Asynchronous reset in the middle of a scan
        xCoordinate = 9'd50; yCoordinate = 8'd30; drawBG = 1'b1;
        repeat (33) @(negedge clock);
        check_val("t5_pre_plot", plot, 1);
        resetn = 1'b0;
        drawBG = 1'b0;
        #1;
        check_val("t5_rst_plot", plot, 0);
        check_val("t5_rst_done", doneBG | doneChar, 0);
        check_val("t5_rst_vgaX", vgaX, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        xCoordinate = 9'd60; yCoordinate = 8'd40; drawBG = 1'b1;
        draw_and_check(1'b0, 60, 40, plots);
        check_val("t5_plots", plots, 64);
        release_req(0);

        // Transparent colour on every even address
        for (int p = 0; p < NPIX; p++)
            char_mem[p] = (p % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        xCoordinate = 9'd30; yCoordinate = 8'd30; drawChar = 1'b1;
        draw_and_check(1'b1, 30, 30, plots);
        check_val("t6_plots", plots, TranspEn ? 32 : 64);
        release_req(0);

        // Randomised draws
        for (int r = 0; r < 8; r++) begin
            int  ax;
            int  ay;
            bit  is_char;
            ax      = $urandom_range(0, 319);
            ay      = $urandom_range(0, 239);
            is_char = 1'($urandom_range(0, 1));
            bg_seed = $urandom;
            for (int p = 0; p < NPIX; p++) char_mem[p] = 3'($urandom_range(0, 7));
            xCoordinate = 9'(ax);
            yCoordinate = 8'(ay);
            if (is_char) drawChar = 1'b1;
            else         drawBG   = 1'b1;
            draw_and_check(is_char, ax, ay, plots);
            release_req(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
